// File: rtl/tbus_pkg.sv
// Shared definitions for the trinity bus (tbus) into the dcache.
// Holds the operation encodings, the bus widths, the request record that
// the arbiter latches, and the arbiter state encoding.
package tbus_pkg;

    localparam int TBUS_AW  = 64;
    localparam int TBUS_DW  = 64;
    localparam int TBUS_OPW = 2;

    localparam logic [TBUS_OPW-1:0] TBUS_OP_READ  = 2'b00;
    localparam logic [TBUS_OPW-1:0] TBUS_OP_WRITE = 2'b01;

    typedef struct packed {
        logic [TBUS_AW-1:0]  index;
        logic [TBUS_DW-1:0]  write_data;
        logic [TBUS_DW-1:0]  write_mask;
        logic [TBUS_OPW-1:0] operation_type;
    } tbus_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_t;

    // Width of an encoded requester index; at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tbus_arbiter_if.sv
// Bundle of the requester-side and dcache-side tbus signals.
//   slave  : the arbiter's view (takes requests, drives the dcache port)
//   master : the surroundings (requesters plus dcache)
// Requester fields are flattened, slice i = [W*i +: W].
interface tbus_arbiter_if
    import tbus_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*TBUS_AW-1:0]  req_index;
    logic [NUM_REQ*TBUS_DW-1:0]  req_write_data;
    logic [NUM_REQ*TBUS_DW-1:0]  req_write_mask;
    logic [NUM_REQ*TBUS_OPW-1:0] req_operation_type;
    logic [TBUS_DW-1:0]          req_read_data;
    logic [NUM_REQ-1:0]          req_operation_done;

    logic                        arb2dcache_index_valid;
    logic                        arb2dcache_index_ready;
    logic [TBUS_AW-1:0]          arb2dcache_index;
    logic [TBUS_DW-1:0]          arb2dcache_write_data;
    logic [TBUS_DW-1:0]          arb2dcache_write_mask;
    logic [TBUS_OPW-1:0]         arb2dcache_operation_type;
    logic [TBUS_DW-1:0]          arb2dcache_read_data;
    logic                        arb2dcache_operation_done;

    modport slave (
        input  req_valid, req_index, req_write_data, req_write_mask, req_operation_type,
        output req_ready, req_read_data, req_operation_done,
        output arb2dcache_index_valid, arb2dcache_index, arb2dcache_write_data,
               arb2dcache_write_mask, arb2dcache_operation_type,
        input  arb2dcache_index_ready, arb2dcache_read_data, arb2dcache_operation_done
    );

    modport master (
        output req_valid, req_index, req_write_data, req_write_mask, req_operation_type,
        input  req_ready, req_read_data, req_operation_done,
        input  arb2dcache_index_valid, arb2dcache_index, arb2dcache_write_data,
               arb2dcache_write_mask, arb2dcache_operation_type,
        output arb2dcache_index_ready, arb2dcache_read_data, arb2dcache_operation_done
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker, reusable by any arbiter.
//   req_valid  : per-requester request
//   last_grant : encoded index of the previous winner
//   grant      : one-hot winner (all zero when nothing is valid)
//   grant_idx  : encoded winner (0 when nothing is valid)
// Search starts at last_grant+1 and wraps modulo NUM_REQ.
module rr_picker
    import tbus_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tbus_arbiter.sv
// Round-robin arbiter sharing the single tbus port into the dcache.
// One transaction outstanding: the winner's fields are latched, issued
// downstream, and held until the dcache reports operation_done, which is
// routed back only to the owning requester.
//   clock, reset    : sole clock; asynchronous active-high reset
//   bus             : requester and dcache signals (slave modport)
//   arb_busy        : a transaction is in flight
//   arb_timeout_err : sticky watchdog flag, cleared only by reset
module tbus_arbiter
    import tbus_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    tbus_arbiter_if.slave     bus,
    output logic              arb_busy,
    output logic              arb_timeout_err
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int WDOG_W = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    tbus_req_t          req_q, req_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    tbus_req_t          sel_req;
    logic [NUM_REQ-1:0] req_ready_c;
    logic               done_fire;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Slice out the winner's fields from the flattened requester buses.
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_req.index          = bus.req_index[TBUS_AW*i +: TBUS_AW];
                sel_req.write_data     = bus.req_write_data[TBUS_DW*i +: TBUS_DW];
                sel_req.write_mask     = bus.req_write_mask[TBUS_DW*i +: TBUS_DW];
                sel_req.operation_type = bus.req_operation_type[TBUS_OPW*i +: TBUS_OPW];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        req_ready_c   = '0;
        done_fire     = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (|grant) begin
                    req_ready_c  = grant;
                    req_d        = sel_req;
                    owner_d      = grant;
                    last_grant_d = grant_idx;
                    wdog_d       = '0;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // A done arriving together with index_ready completes at once.
                if (bus.arb2dcache_index_ready) begin
                    if (bus.arb2dcache_operation_done) begin
                        done_fire = 1'b1;
                        state_d   = ARB_IDLE;
                    end else begin
                        state_d   = ARB_WAIT_DONE;
                    end
                end
            end
            ARB_WAIT_DONE: begin
                if (bus.arb2dcache_operation_done) begin
                    done_fire = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Watchdog only observes; the FSM keeps waiting after it fires.
        if (state_q != ARB_IDLE) begin
            if (wdog_q == WDOG_MAX) begin
                timeout_err_d = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            req_q         <= '0;
            owner_q       <= '0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.req_ready                 = req_ready_c;
    assign bus.req_operation_done        = done_fire ? owner_q : '0;
    assign bus.req_read_data             = bus.arb2dcache_read_data;
    assign bus.arb2dcache_index_valid    = (state_q == ARB_ISSUE);
    assign bus.arb2dcache_index          = req_q.index;
    assign bus.arb2dcache_write_data     = req_q.write_data;
    assign bus.arb2dcache_write_mask     = req_q.write_mask;
    assign bus.arb2dcache_operation_type = req_q.operation_type;
    assign arb_busy                      = (state_q != ARB_IDLE);
    assign arb_timeout_err               = timeout_err_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
module tb_tbus_arbiter;
    import tbus_pkg::*;

    localparam int NR = 3;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tbus_arbiter_if #(.NUM_REQ(NR)) bus ();
    logic arb_busy, arb_timeout_err;

    tbus_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .arb_busy        (arb_busy),
        .arb_timeout_err (arb_timeout_err)
    );

    // Stimulus
    logic [2:0]  rv;
    logic [63:0] idx [NR];
    logic [63:0] wd  [NR];
    logic [63:0] wm  [NR];
    logic [1:0]  ot  [NR];
    logic        dc_ready, dc_done;
    logic [63:0] dc_rdata;

    assign bus.req_valid                 = rv;
    assign bus.req_index                 = {idx[2], idx[1], idx[0]};
    assign bus.req_write_data            = {wd[2], wd[1], wd[0]};
    assign bus.req_write_mask            = {wm[2], wm[1], wm[0]};
    assign bus.req_operation_type        = {ot[2], ot[1], ot[0]};
    assign bus.arb2dcache_index_ready    = dc_ready;
    assign bus.arb2dcache_operation_done = dc_done;
    assign bus.arb2dcache_read_data      = dc_rdata;

    // Transaction-level reference: who owns the bus, whether its request has
    // been handed to the dcache, and how many busy cycles have elapsed.
    int          m_owner;
    int          m_last;
    int          m_busy;
    bit          m_issued;
    bit          m_err;
    logic [63:0] m_idx, m_wd, m_wm;
    logic [1:0]  m_ot;
    logic [2:0]  m_acc;

    int n_checks;
    int n_err;
    int gq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] v, input int last);
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [2:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = NR - 1; m_busy = 0;
        m_issued = 1'b0; m_err = 1'b0;
        m_idx = '0; m_wd = '0; m_wm = '0; m_ot = '0; m_acc = '0;
    endtask

    task automatic clear_inputs();
        rv = '0; dc_ready = 1'b0; dc_done = 1'b0; dc_rdata = '0;
        for (int i = 0; i < NR; i++) begin
            idx[i] = '0; wd[i] = '0; wm[i] = '0; ot[i] = '0;
        end
    endtask

    // Let inputs settle, then compare every output with the reference.
    task automatic eval();
        int p;
        logic [2:0] e_ready, e_done;
        bit e_valid;
        #1;
        p       = rr_pick(rv, m_last);
        e_ready = (m_owner < 0 && p >= 0) ? 3'(1 << p) : 3'b000;
        e_valid = (m_owner >= 0) && !m_issued;
        e_done  = (m_owner >= 0 && (m_issued || dc_ready) && dc_done) ? 3'(1 << m_owner) : 3'b000;
        chk("req_ready", 64'(bus.req_ready), 64'(e_ready));
        chk("idx_valid", 64'(bus.arb2dcache_index_valid), 64'(e_valid));
        chk("op_done", 64'(bus.req_operation_done), 64'(e_done));
        chk("busy", 64'(arb_busy), 64'(m_owner >= 0));
        chk("timeout_err", 64'(arb_timeout_err), 64'(m_err));
        chk("read_data", bus.req_read_data, dc_rdata);
        if (e_valid) begin
            chk("ds_index", bus.arb2dcache_index, m_idx);
            chk("ds_wdata", bus.arb2dcache_write_data, m_wd);
            chk("ds_wmask", bus.arb2dcache_write_mask, m_wm);
            chk("ds_optype", 64'(bus.arb2dcache_operation_type), 64'(m_ot));
        end
    endtask

    // Advance the reference across the coming rising edge, then wait for it.
    task automatic adv();
        int p;
        bit fire;
        p     = rr_pick(rv, m_last);
        m_acc = '0;
        if (m_owner < 0) begin
            if (p >= 0) begin
                m_owner = p; m_last = p; m_acc = 3'(1 << p);
                m_idx = idx[p]; m_wd = wd[p]; m_wm = wm[p]; m_ot = ot[p];
                m_issued = 1'b0; m_busy = 0;
            end
        end else begin
            fire = (m_issued || dc_ready) && dc_done;
            m_busy++;
            if (m_busy >= TO) m_err = 1'b1;
            if (fire) m_owner = -1;
            else if (!m_issued && dc_ready) m_issued = 1'b1;
        end
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        clear_inputs();
        model_reset();
        reset = 1'b1;

        // Reset state
        eval();
        chk("rst_index", bus.arb2dcache_index, 64'h0);
        chk("rst_wdata", bus.arb2dcache_write_data, 64'h0);
        chk("rst_wmask", bus.arb2dcache_write_mask, 64'h0);
        @(negedge clock);
        reset = 1'b0;

        // All requesters valid: strict rotation 0,1,2,0
        for (int i = 0; i < NR; i++) idx[i] = 64'h1000 * 64'(i + 1);
        rv = 3'b111; dc_ready = 1'b1; dc_done = 1'b1;
        repeat (8) begin
            eval();
            if (bus.req_ready != 3'b000) gq.push_back(oh2i(bus.req_ready));
            adv();
        end
        chk("rr_count", 64'(gq.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            if (k < gq.size()) chk("rr_order", 64'(gq[k]), 64'(k % NR));
        clear_inputs();

        // Single load from requester 1
        rv = 3'b010; idx[1] = 64'h8000_0010; ot[1] = TBUS_OP_READ;
        eval(); chk("load_ready", 64'(bus.req_ready), 64'b010); adv();
        rv = 3'b000;
        eval(); chk("load_valid_n1", 64'(bus.arb2dcache_index_valid), 64'd1); adv();
        dc_ready = 1'b1; eval(); adv(); dc_ready = 1'b0;
        eval(); adv();
        eval(); adv();
        dc_done = 1'b1; dc_rdata = 64'hDEAD_BEEF;
        eval();
        chk("load_done", 64'(bus.req_operation_done), 64'b010);
        chk("load_rdata", bus.req_read_data, 64'hDEAD_BEEF);
        adv();
        dc_done = 1'b0; dc_rdata = '0;
        eval(); chk("load_idle", 64'(arb_busy), 64'd0); adv();

        // Store from requester 0, then a stray done while idle
        rv = 3'b001; idx[0] = 64'h0000_0000_0000_1238;
        wd[0] = 64'h0000_0000_CAFE_0000; wm[0] = 64'h0000_0000_FFFF_0000; ot[0] = TBUS_OP_WRITE;
        eval(); adv();
        rv = 3'b000;
        eval();
        chk("store_index", bus.arb2dcache_index, 64'h0000_0000_0000_1238);
        chk("store_wdata", bus.arb2dcache_write_data, 64'h0000_0000_CAFE_0000);
        chk("store_mask", bus.arb2dcache_write_mask, 64'h0000_0000_FFFF_0000);
        chk("store_type", 64'(bus.arb2dcache_operation_type), 64'b01);
        dc_ready = 1'b1; adv(); dc_ready = 1'b0;
        eval(); adv();
        dc_done = 1'b1;
        eval(); chk("store_done", 64'(bus.req_operation_done), 64'b001); adv();
        eval(); chk("stray_done", 64'(bus.req_operation_done), 64'b000); adv();
        dc_done = 1'b0;

        // ready and done in the same ISSUE cycle
        rv = 3'b100; idx[2] = 64'hABCD_0000_0000_0040; ot[2] = 2'b11;
        eval(); adv();
        rv = 3'b000; dc_ready = 1'b1; dc_done = 1'b1;
        eval(); chk("same_cyc_done", 64'(bus.req_operation_done), 64'b100); adv();
        dc_ready = 1'b0; dc_done = 1'b0; rv = 3'b001;
        eval();
        chk("next_grant", 64'(bus.req_ready), 64'b001);
        adv();
        rv = 3'b000; dc_ready = 1'b1; dc_done = 1'b1;
        eval(); adv();
        clear_inputs();

        // Randomized traffic
        repeat (600) begin
            for (int i = 0; i < NR; i++) begin
                if (!rv[i] || m_acc[i]) begin
                    rv[i]  = ($urandom_range(0, 99) < 40);
                    idx[i] = {$urandom, $urandom};
                    wd[i]  = {$urandom, $urandom};
                    wm[i]  = {$urandom, $urandom};
                    ot[i]  = 2'($urandom_range(0, 3));
                end else if ($urandom_range(0, 7) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            dc_ready = 1'($urandom_range(0, 1));
            dc_done  = ($urandom_range(0, 99) < 30);
            dc_rdata = {$urandom, $urandom};
            eval();
            adv();
        end
        clear_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // Watchdog: done withheld
        rv = 3'b001; idx[0] = 64'h0000_0000_0000_0F00;
        eval(); adv();
        rv = 3'b000; dc_ready = 1'b1;
        for (int b = 1; b <= TO; b++) begin
            eval();
            if (b == TO) chk("wd_not_yet", 64'(arb_timeout_err), 64'd0);
            adv();
            dc_ready = 1'b0;
        end
        eval(); chk("wd_err", 64'(arb_timeout_err), 64'd1); adv();
        repeat (3) begin eval(); adv(); end
        dc_done = 1'b1; eval(); adv(); dc_done = 1'b0;
        eval();
        chk("wd_sticky", 64'(arb_timeout_err), 64'd1);
        chk("wd_idle", 64'(arb_busy), 64'd0);
        adv();

        // Async reset while waiting for done
        rv = 3'b010; idx[1] = 64'h0000_0000_0000_2220;
        eval(); adv();
        rv = 3'b000; dc_ready = 1'b1;
        eval(); adv();
        dc_ready = 1'b0;
        eval(); chk("wait_busy", 64'(arb_busy), 64'd1);
        reset = 1'b1; dc_done = 1'b1;
        #1;
        model_reset();
        chk("rst_busy", 64'(arb_busy), 64'd0);
        chk("rst_err", 64'(arb_timeout_err), 64'd0);
        chk("rst_valid", 64'(bus.arb2dcache_index_valid), 64'd0);
        chk("rst_idx_mid", bus.arb2dcache_index, 64'h0);
        chk("rst_done", 64'(bus.req_operation_done), 64'b000);
        chk("rst_ready", 64'(bus.req_ready), 64'b000);
        @(negedge clock);
        dc_done = 1'b0; reset = 1'b0;
        rv = 3'b111;
        eval(); chk("post_rst_first", 64'(bus.req_ready), 64'b001); adv();
        clear_inputs();
        dc_ready = 1'b1; dc_done = 1'b1;
        eval(); adv();
        clear_inputs();
        eval(); adv();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
